// File: rtl/hv_timing_seq.sv
// Video timing sequencer: steps and reloads the external 9-bit H/V counter chains and
// decodes their counts into registered blanking/sync signals.
module hv_timing_seq #(
  parameter int unsigned CEN_DIV      = 4,
  parameter logic [8:0]  H_LOAD       = 9'h080,
  parameter logic [8:0]  V_LOAD       = 9'h0F8,
  parameter logic [8:0]  HBLANK_START = 9'h180,
  parameter logic [8:0]  HBLANK_END   = 9'h080,
  parameter logic [8:0]  HSYNC_START  = 9'h1A0,
  parameter logic [8:0]  HSYNC_END    = 9'h1C0,
  parameter logic [8:0]  VBLANK_START = 9'h1F0,
  parameter logic [8:0]  VBLANK_END   = 9'h110,
  parameter logic [8:0]  VSYNC_START  = 9'h100,
  parameter logic [8:0]  VSYNC_END    = 9'h104
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Run,
  input  logic [8:0] H_Q,
  input  logic [8:0] V_Q,
  input  logic       H_Rco,
  input  logic       V_Rco,
  output logic       Cen,
  output logic       H_Load_n,
  output logic [8:0] H_D,
  output logic       V_ENT,
  output logic       V_Load_n,
  output logic [8:0] V_D,
  output logic       HBlank,
  output logic       VBlank,
  output logic       HSync_n,
  output logic       VSync_n,
  output logic       Frame_start,
  output logic       Running
);

  localparam int unsigned DivW = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CEN_DIV - 1);

  typedef enum logic [1:0] {StIdle, StPreload, StRun, StStopping} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic            cen_tick;
  logic            wrap;

  // Wrap-around window: S<=E is a plain range, S>E spans the 511->0 rollover, S==E is empty.
  function automatic logic win(input logic [8:0] x, input logic [8:0] s, input logic [8:0] e);
    if (s == e) begin
      return 1'b0;
    end else if (s < e) begin
      return (x >= s) && (x < e);
    end else begin
      return (x >= s) || (x < e);
    end
  endfunction

  assign H_D      = H_LOAD;
  assign V_D      = V_LOAD;
  assign Running  = (state_q != StIdle);
  assign cen_tick = (div_q == DivMax) && (state_q != StIdle);
  assign wrap     = H_Rco & V_Rco;

  always_comb begin
    state_d     = state_q;
    div_d       = '0;
    Cen         = 1'b0;
    H_Load_n    = 1'b1;
    V_Load_n    = 1'b1;
    V_ENT       = 1'b0;
    Frame_start = 1'b0;

    if (state_q != StIdle) begin
      div_d = cen_tick ? '0 : div_q + 1'b1;
      Cen   = cen_tick;
    end

    unique case (state_q)
      StIdle: begin
        if (Run) state_d = StPreload;
      end
      StPreload: begin
        H_Load_n = 1'b0;
        V_Load_n = 1'b0;
        if (cen_tick) begin
          Frame_start = 1'b1;
          state_d     = StRun;
        end
      end
      StRun, StStopping: begin
        // Combinational so the controls are already valid on the Cen cycle.
        H_Load_n = ~H_Rco;
        V_ENT    = H_Rco;
        V_Load_n = ~wrap;
        if (cen_tick && wrap) Frame_start = 1'b1;
        if (state_q == StRun) begin
          if (!Run) state_d = StStopping;
        end else if (Run) begin
          state_d = StRun;
        end else if (cen_tick && wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  // Decode runs every cycle; in IDLE the counts are frozen so the outputs hold.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      HBlank  <= 1'b1;
      VBlank  <= 1'b1;
      HSync_n <= 1'b1;
      VSync_n <= 1'b1;
    end else begin
      HBlank  <= win(H_Q, HBLANK_START, HBLANK_END);
      VBlank  <= win(V_Q, VBLANK_START, VBLANK_END);
      HSync_n <= ~win(H_Q, HSYNC_START, HSYNC_END);
      VSync_n <= ~win(V_Q, VSYNC_START, VSYNC_END);
    end
  end

endmodule

// File: doc/hv_timing_seq.md
# hv_timing_seq

Sequencer for the cascaded 9-bit horizontal and vertical 74163-style counter chains that form the video timing generator. The block produces the single-cycle counter clock-enable strobe. It also drives the parallel-load and enable controls so that both chains preload, wrap and cascade correctly. It decodes the chain outputs into registered blanking and sync signals and a frame-start strobe, and sits between the system clock domain and the timing counters.

## Interface
- CEN_DIV, 4: Clk cycles per counter step (≥2).
- H_LOAD, 9'h080: H chain reload value (line = 512−H_LOAD = 384 steps).
- V_LOAD, 9'h0F8: V chain reload value (frame = 264 lines).
- HBLANK_START / HBLANK_END, 9'h180 / 9'h080: HBlank window.
- HSYNC_START / HSYNC_END, 9'h1A0 / 9'h1C0: HSync window.
- VBLANK_START / VBLANK_END, 9'h1F0 / 9'h110: VBlank window.
- VSYNC_START / VSYNC_END, 9'h100 / 9'h104: VSync window.

Ports:
- Clk  in  1  system clock. All logic is on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Run  in  1  level request to run timing.
- H_Q  in  9  H chain count.
- V_Q  in  9  V chain count.
- H_Rco  in  1  H chain terminal count (H_Q==511).
- V_Rco  in  1  V chain terminal count, gated by V_ENT.
- Cen  out  1  counter step strobe, shared by both chains.
- H_Load_n  out  1  H chain Load_bar.
- H_D  out  9  H chain D, constant H_LOAD.
- V_ENT  out  1  V chain ENT and ENP.
- V_Load_n  out  1  V chain Load_bar.
- V_D  out  9  V chain D, constant V_LOAD.
- HBlank, VBlank  out  1  blanking, active high.
- HSync_n, VSync_n  out  1  sync, active low.
- Frame_start  out  1  one-cycle strobe.
- Running  out  1  high in PRELOAD, RUN and STOPPING.

The H chain has ENT and ENP tied high. Both chains have Clear_bar tied high.

## Operation
- States: IDLE, PRELOAD, RUN, STOPPING.
- Divider:
  - div counts 0..CEN_DIV−1 in every state except IDLE. It is held at 0 in IDLE.
  - Cen=1 exactly on cycles where div==CEN_DIV−1, so Cen is one Clk wide. Cen is 0 in IDLE.
- IDLE:
  - Outputs: H_Load_n=1, V_Load_n=1, V_ENT=0.
  - Run=1 → PRELOAD.
- PRELOAD:
  - H_Load_n=0 and V_Load_n=0 for the whole state.
  - On the first Cen the chains load H_LOAD and V_LOAD, Frame_start pulses, and the state goes to RUN.
  - Run dropping during PRELOAD is ignored.
- RUN:
  - H_Load_n = ~H_Rco.
  - V_ENT = H_Rco.
  - V_Load_n = ~(H_Rco & V_Rco).
  - These are combinational from the inputs so they are valid when Cen is asserted.
  - Frame wrap is a Cen cycle with H_Rco & V_Rco. On frame wrap, Frame_start pulses.
  - Run=0 → STOPPING.
- STOPPING:
  - Same outputs as RUN.
  - Run=1 → RUN, with no reload and no glitch.
  - At frame wrap the reload still occurs, Frame_start pulses, and the state goes to IDLE.
- Window decode, with W(x,S,E) defined as follows:
  - If S≤E: S≤x<E.
  - Otherwise: x≥S or x<E.
  - If S==E the window is always empty.
- Decoded outputs:
  - HBlank = W(H_Q, HBLANK_START, HBLANK_END).
  - HSync_n = ~W(H_Q, HSYNC…).
  - VBlank and VSync_n are the same form on V_Q.
  - All four are registered every Clk, regardless of state. They hold their last values in IDLE.
- Reset values (async): state IDLE, div 0, Cen 0, H_Load_n 1, V_Load_n 1, V_ENT 0, HBlank 1, VBlank 1, HSync_n 1, VSync_n 1, Frame_start 0, Running 0.
- H_D and V_D are constant and not reset-dependent.
- Reset asserted mid-frame forces the reset values immediately. No pending load is completed.

## Timing
- Counters step on the Clk edge where Cen=1. New Q values are visible the following cycle.
- Decoded sync and blank outputs follow a Q change by one Clk, i.e. 2 Clk after the Cen cycle.
- Run rise to first Cen: CEN_DIV Clk (+1 cycle for the IDLE→PRELOAD registration).
- Frame_start is coincident with the reload Cen cycle.
- Running: asserted the cycle after the IDLE→PRELOAD edge; deasserted the cycle after the STOPPING→IDLE edge.
- Line period = (512−H_LOAD)·CEN_DIV Clk. Frame period = line period · (512−V_LOAD).

## Test plan
Each scenario uses a bench with two 9-bit counter models and default parameters.
- Reset and Run=0: hold 20 cycles → all outputs at reset values, Cen never 1.
- Run=1 after reset: H_Load_n=V_Load_n=0 until the first Cen (cycle 5), then H_Q=0x080, V_Q=0x0F8, one Frame_start. Cen then repeats every 4 Clk.
- Line wrap at H_Q=511, V_Q=0x0F8: during that Cen, H_Load_n=0, V_ENT=1, V_Load_n=1. The next cycle shows H_Q=0x080, V_Q=0x0F9.
- Frame wrap at H_Q=511, V_Q=511: V_Load_n=0 and Frame_start=1 in the same cycle. Frame period is 384·264·4=405504 Clk.
- Decode at H_Q=0x180: HBlank rises 2 Clk after the Cen. At H_Q=0x1A0, HSync_n falls. At V_Q=0x100, VSync_n=0; at V_Q=0x104, VSync_n=1.
- Stop: Run=0 mid-frame → counting continues to frame wrap, then IDLE, Cen stops, Running=0.
  - Run toggled 0→1 before wrap → stays counting with no extra Frame_start.
  - Rst_n pulsed mid-line → immediate reset values.
